// File: rtl/pwr_seq_ctrl.sv
// rtl/pwr_seq_ctrl.sv - thermometer-coded power-rail sequencer with programmable step delay
//
// Ramps NUM_STEPS rail enables up/down one step at a time. It supports full off,
// partial power-down to DWN_LEVEL, reversal mid-ramp, a one-time system reset
// release and a ROIC reset pulse.
//
// Optional feature macro: PWR_SEQ_FAULT_EN (fault latch, FAULT state, immediate rails-off).
//
// Ports:
//   fsm_clk     in   sole clock
//   reset       in   asynchronous active-low reset
//   en_pwr_off  in   async level, request all rails off
//   en_pwr_dwn  in   async level, request ramp to DWN_LEVEL
//   fault       in   async rail fault, active high
//   fault_clr   in   synchronous single-cycle fault clear
//   pwr_step    out  thermometer rail enables, bit k-1 on when level >= k
//   init_rst_n  out  system reset, released once after first full ramp
//   roic_reset  out  ROIC reset pulse, ROIC_RST_LEN cycles
//   seq_state   out  state code: OFF=0 UP=1 HOLD=2 DOWN=3 FAULT=4
//   busy        out  level differs from target
module pwr_seq_ctrl #(
    parameter int NUM_STEPS    = 6,
    parameter int CNT_W        = 25,
    parameter int STEP_DELAY   = 1000,
    parameter int LONG_STEP    = 5,
    parameter int LONG_DELAY   = 3000,
    parameter int DWN_LEVEL    = 3,
    parameter int ROIC_STEP    = 5,
    parameter int ROIC_RST_LEN = 4
) (
    input  logic                 fsm_clk,
    input  logic                 reset,
    input  logic                 en_pwr_off,
    input  logic                 en_pwr_dwn,
    input  logic                 fault,
    input  logic                 fault_clr,
    output logic [NUM_STEPS-1:0] pwr_step,
    output logic                 init_rst_n,
    output logic                 roic_reset,
    output logic [2:0]           seq_state,
    output logic                 busy
);

    localparam int LW = $clog2(NUM_STEPS + 1);
    localparam int RW = $clog2(ROIC_RST_LEN + 1);

    localparam logic [LW-1:0]    LVL_MAX   = LW'(NUM_STEPS);
    localparam logic [LW-1:0]    LVL_DWN   = LW'(DWN_LEVEL);
    localparam logic [LW-1:0]    LVL_LONG  = LW'(LONG_STEP - 1);
    localparam logic [LW-1:0]    LVL_ROIC  = LW'(ROIC_STEP);
    localparam logic [LW-1:0]    LVL_ROICM = LW'(ROIC_STEP - 1);
    localparam logic [CNT_W-1:0] D_STEP    = CNT_W'(STEP_DELAY);
    localparam logic [CNT_W-1:0] D_LONG    = CNT_W'(LONG_DELAY);
    localparam logic [RW-1:0]    ROIC_LOAD = RW'(ROIC_RST_LEN - 1);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_UP    = 3'd1,
        S_HOLD  = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    logic off_s1_q, off_s2_q, dwn_s1_q, dwn_s2_q;
    logic fault_lat;

    logic [LW-1:0]        lvl_q, lvl_d, lvl_prev_q, tgt;
    logic [CNT_W-1:0]     cnt_q, cnt_d, delay;
    logic                 dir_up_q, dir_up_d;
    state_t               state_q, state_d;
    logic [NUM_STEPS-1:0] step_q, step_d;
    logic                 busy_q;
    logic                 full_d1_q, full_d2_q, init_q;
    logic [RW-1:0]        roic_cnt_q;
    logic                 roic_q;
    logic                 roic_hit;

`ifdef PWR_SEQ_FAULT_EN
    logic flt_s1_q, flt_s2_q, flt_hold_q;

    // The latch is the synced fault ORed with a sticky copy, so rails drop as
    // soon as the synchroniser output rises; only fault_clr with the fault
    // gone releases the sticky copy.
    assign fault_lat = flt_s2_q | flt_hold_q;

    always_ff @(posedge fsm_clk or negedge reset) begin
        if (!reset) begin
            flt_s1_q   <= 1'b0;
            flt_s2_q   <= 1'b0;
            flt_hold_q <= 1'b0;
        end else begin
            flt_s1_q <= fault;
            flt_s2_q <= flt_s1_q;
            if (flt_s2_q) begin
                flt_hold_q <= 1'b1;
            end else if (fault_clr) begin
                flt_hold_q <= 1'b0;
            end
        end
    end
`else
    logic unused_fault_in;
    assign unused_fault_in = fault ^ fault_clr;
    assign fault_lat       = 1'b0;
`endif

    always_comb begin
        tgt = LVL_MAX;
        if (fault_lat) begin
            tgt = '0;
        end else if (off_s2_q) begin
            tgt = '0;
        end else if (dwn_s2_q) begin
            tgt = LVL_DWN;
        end
    end

    // Only the step up into LONG_STEP gets the long settling delay.
    assign delay = (tgt > lvl_q && lvl_q == LVL_LONG) ? D_LONG : D_STEP;

    always_comb begin
        lvl_d    = lvl_q;
        cnt_d    = '0;
        dir_up_d = dir_up_q;
        if (fault_lat) begin
            lvl_d = '0;
        end else if (lvl_q != tgt) begin
            dir_up_d = (tgt > lvl_q);
            // A direction reversal restarts the interval at the current level.
            if (dir_up_d != dir_up_q) begin
                cnt_d = '0;
            end else if (cnt_q == delay) begin
                lvl_d = dir_up_q ? lvl_q + LW'(1) : lvl_q - LW'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        if (fault_lat) begin
            state_d = S_FAULT;
        end else if (lvl_d == tgt) begin
            state_d = (tgt == '0) ? S_OFF : S_HOLD;
        end else if (lvl_d < tgt) begin
            state_d = S_UP;
        end else begin
            state_d = S_DOWN;
        end
    end

    always_comb begin
        step_d = '0;
        for (int k = 0; k < NUM_STEPS; k++) begin
            step_d[k] = (lvl_d > LW'(k));
        end
    end

    // One cycle after the level has stepped from ROIC_STEP-1 to ROIC_STEP.
    assign roic_hit = (lvl_q == LVL_ROIC) && (lvl_prev_q == LVL_ROICM);

    always_ff @(posedge fsm_clk or negedge reset) begin
        if (!reset) begin
            off_s1_q   <= 1'b0;
            off_s2_q   <= 1'b0;
            dwn_s1_q   <= 1'b0;
            dwn_s2_q   <= 1'b0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            cnt_q      <= '0;
            dir_up_q   <= 1'b1;
            state_q    <= S_OFF;
            step_q     <= '0;
            busy_q     <= 1'b0;
            full_d1_q  <= 1'b0;
            full_d2_q  <= 1'b0;
            init_q     <= 1'b0;
            roic_cnt_q <= '0;
            roic_q     <= 1'b0;
        end else begin
            off_s1_q   <= en_pwr_off;
            off_s2_q   <= off_s1_q;
            dwn_s1_q   <= en_pwr_dwn;
            dwn_s2_q   <= dwn_s1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            cnt_q      <= cnt_d;
            dir_up_q   <= dir_up_d;
            state_q    <= state_d;
            step_q     <= step_d;
            busy_q     <= (lvl_d != tgt);

            // Rising edge of "fully up", seen through two delay flops; sticky.
            full_d1_q <= (lvl_q == LVL_MAX);
            full_d2_q <= full_d1_q;
            if (full_d1_q && !full_d2_q) begin
                init_q <= 1'b1;
            end

            if (roic_hit) begin
                roic_q     <= 1'b1;
                roic_cnt_q <= ROIC_LOAD;
            end else if (roic_cnt_q != '0) begin
                roic_cnt_q <= roic_cnt_q - RW'(1);
            end else begin
                roic_q <= 1'b0;
            end
        end
    end

    assign pwr_step   = step_q;
    assign init_rst_n = init_q;
    assign roic_reset = roic_q;
    assign seq_state  = state_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb/tb_pwr_seq_ctrl.sv - directed self-checking bench for pwr_seq_ctrl
module tb_pwr_seq_ctrl;

    logic       fsm_clk = 1'b0;
    logic       reset;
    logic       en_pwr_off, en_pwr_dwn, fault, fault_clr;
    logic [5:0] pwr_step;
    logic       init_rst_n, roic_reset, busy;
    logic [2:0] seq_state;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pwr_seq_ctrl #(
        .NUM_STEPS   (6),
        .CNT_W       (25),
        .STEP_DELAY  (10),
        .LONG_STEP   (5),
        .LONG_DELAY  (30),
        .DWN_LEVEL   (3),
        .ROIC_STEP   (5),
        .ROIC_RST_LEN(4)
    ) dut (
        .fsm_clk   (fsm_clk),
        .reset     (reset),
        .en_pwr_off(en_pwr_off),
        .en_pwr_dwn(en_pwr_dwn),
        .fault     (fault),
        .fault_clr (fault_clr),
        .pwr_step  (pwr_step),
        .init_rst_n(init_rst_n),
        .roic_reset(roic_reset),
        .seq_state (seq_state),
        .busy      (busy)
    );

    always #5 fsm_clk = ~fsm_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp_v);
        end
    endtask

    task automatic edge1();
        @(posedge fsm_clk);
        #1;
    endtask

    task automatic edges(input int n);
        repeat (n) edge1();
    endtask

    // Full ramp from reset release; first loop edge is edge 1.
    task automatic ramp_check(input string p);
        int r_first, r_last, r_n;
        r_first = 0;
        r_last  = 0;
        r_n     = 0;
        for (int e = 1; e <= 90; e++) begin
            edge1();
            if (roic_reset === 1'b1) begin
                if (r_n == 0) r_first = e;
                r_last = e;
                r_n++;
            end
            case (e)
                1:  begin chk({p, "_busy1"}, 32'(busy), 1); chk({p, "_st1"}, 32'(seq_state), 1); end
                10: chk({p, "_e10"}, 32'(pwr_step), 'h00);
                11: chk({p, "_e11"}, 32'(pwr_step), 'h01);
                21: chk({p, "_e21"}, 32'(pwr_step), 'h01);
                22: chk({p, "_e22"}, 32'(pwr_step), 'h03);
                33: chk({p, "_e33"}, 32'(pwr_step), 'h07);
                44: chk({p, "_e44"}, 32'(pwr_step), 'h0F);
                74: chk({p, "_e74"}, 32'(pwr_step), 'h0F);
                75: chk({p, "_e75"}, 32'(pwr_step), 'h1F);
                85: begin chk({p, "_e85"}, 32'(pwr_step), 'h1F); chk({p, "_busy85"}, 32'(busy), 1); end
                86: begin
                    chk({p, "_e86"}, 32'(pwr_step), 'h3F);
                    chk({p, "_busy86"}, 32'(busy), 0);
                    chk({p, "_st86"}, 32'(seq_state), 2);
                end
                87: chk({p, "_init87"}, 32'(init_rst_n), 0);
                88: chk({p, "_init88"}, 32'(init_rst_n), 1);
                default: ;
            endcase
        end
        chk({p, "_roic_first"}, 32'(r_first), 76);
        chk({p, "_roic_last"}, 32'(r_last), 79);
        chk({p, "_roic_len"}, 32'(r_n), 4);
    endtask

    initial begin
        int  found;
        logic lost;

        reset      = 1'b0;
        en_pwr_off = 1'b0;
        en_pwr_dwn = 1'b0;
        fault      = 1'b0;
        fault_clr  = 1'b0;
        edges(3);
        chk("rst_pwr", 32'(pwr_step), 0);
        chk("rst_init", 32'(init_rst_n), 0);
        chk("rst_roic", 32'(roic_reset), 0);
        chk("rst_state", 32'(seq_state), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;

        ramp_check("ramp1");

        // Power-down to retention level and back.
        en_pwr_dwn = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            edge1();
            case (e)
                13: chk("dwn_e13", 32'(pwr_step), 'h3F);
                14: chk("dwn_e14", 32'(pwr_step), 'h1F);
                25: chk("dwn_e25", 32'(pwr_step), 'h0F);
                35: chk("dwn_e35", 32'(pwr_step), 'h0F);
                36: chk("dwn_e36", 32'(pwr_step), 'h07);
                default: ;
            endcase
        end
        chk("dwn_state", 32'(seq_state), 2);
        chk("dwn_busy", 32'(busy), 0);
        en_pwr_dwn = 1'b0;
        for (int e = 1; e <= 60; e++) begin
            edge1();
            case (e)
                13: chk("up_e13", 32'(pwr_step), 'h07);
                14: chk("up_e14", 32'(pwr_step), 'h0F);
                44: chk("up_e44", 32'(pwr_step), 'h0F);
                45: chk("up_e45", 32'(pwr_step), 'h1F);
                56: chk("up_e56", 32'(pwr_step), 'h3F);
                default: ;
            endcase
        end
        chk("up_init", 32'(init_rst_n), 1);

        // Power-off, reversed at level 4.
        en_pwr_off = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            edge1();
            case (e)
                13: chk("off_e13", 32'(pwr_step), 'h3F);
                14: chk("off_e14", 32'(pwr_step), 'h1F);
                25: chk("off_e25", 32'(pwr_step), 'h0F);
                default: ;
            endcase
        end
        en_pwr_off = 1'b0;
        lost = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            edge1();
            if (pwr_step != 6'h0F && pwr_step != 6'h1F && pwr_step != 6'h3F) lost = 1'b1;
            case (e)
                33: chk("rev_e33", 32'(pwr_step), 'h0F);
                34: chk("rev_e34", 32'(pwr_step), 'h1F);
                45: chk("rev_e45", 32'(pwr_step), 'h3F);
                default: ;
            endcase
        end
        chk("rev_nolost", 32'(lost), 0);
        chk("rev_init", 32'(init_rst_n), 1);

        // Reset at level 3 mid-count.
        reset = 1'b0;
        edges(2);
        reset = 1'b1;
        edges(38);
        chk("mid_lvl3", 32'(pwr_step), 'h07);
        reset = 1'b0;
        #1;
        chk("mid_rst_pwr", 32'(pwr_step), 0);
        chk("mid_rst_init", 32'(init_rst_n), 0);
        chk("mid_rst_state", 32'(seq_state), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        edges(2);
        reset = 1'b1;
        ramp_check("ramp2");

        // Fault at level 4 during ramp-up.
        reset = 1'b0;
        edges(2);
        reset = 1'b1;
        edges(50);
        chk("flt_pre_pwr", 32'(pwr_step), 'h0F);
        chk("flt_pre_st", 32'(seq_state), 1);
        fault = 1'b1;
`ifdef PWR_SEQ_FAULT_EN
        edges(2);
        chk("flt_e2", 32'(pwr_step), 'h0F);
        edge1();
        chk("flt_e3_pwr", 32'(pwr_step), 0);
        chk("flt_e3_st", 32'(seq_state), 4);
        chk("flt_e3_busy", 32'(busy), 0);
        fault_clr = 1'b1;
        edge1();
        fault_clr = 1'b0;
        edges(2);
        chk("flt_clr_ign_st", 32'(seq_state), 4);
        chk("flt_clr_ign_pwr", 32'(pwr_step), 0);
        fault = 1'b0;
        edges(4);
        chk("flt_hold_st", 32'(seq_state), 4);
        fault_clr = 1'b1;
        edge1();
        fault_clr = 1'b0;
        chk("flt_clr_edge_st", 32'(seq_state), 4);
        edge1();
        chk("flt_resume_st", 32'(seq_state), 1);
        found = 0;
        for (int e = 1; e <= 20; e++) begin
            edge1();
            if (found == 0 && pwr_step == 6'h01) found = e;
        end
        chk("flt_resume_found", 32'(found != 0), 1);
`else
        edges(5);
        chk("flt_ign_pwr", 32'(pwr_step), 'h0F);
        chk("flt_ign_st", 32'(seq_state), 1);
        fault_clr = 1'b1;
        edge1();
        fault_clr = 1'b0;
        fault     = 1'b0;
        found = 0;
        for (int e = 1; e <= 30; e++) begin
            edge1();
            if (found == 0 && pwr_step == 6'h1F) found = e;
        end
        chk("flt_ign_continue", 32'(found != 0), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
